uart_cmd_ctrl: RTL and testbench
================================

// Module: uart_cmd_ctrl
// PURPOSE
//  Command sequencer behind the UART receiver. Parses byte frames from the RX datapath into
//  register-file write/read and ALU commands, drives the register file and ALU, and hands
//  result bytes to the UART transmitter. Sits between UART_RX, reg file, ALU and UART_TX.
//  Also owns the ALU clock-gate enable.
// PARAMETERS
//  DATA_WIDTH     8   byte width of RX/TX/reg-file data
//  ADDR_WIDTH     4   reg-file address width
//  ALU_FUN_WIDTH  4   ALU function code width
// PORTS
//  clk          in   1    system clock (reg-file/ALU domain)
//  rst          in   1    synchronous, active-high reset
//  rx_p_data    in   8    received byte, valid when rx_d_valid=1
//  rx_d_valid   in   1    one-cycle pulse per received byte
//  rx_frame_err in   1    parity|stop error qualifying the current rx_d_valid pulse
//  rf_wr_en     out  1    reg-file write strobe (1 cycle)
//  rf_rd_en     out  1    reg-file read strobe (1 cycle)
//  rf_addr      out  4    reg-file address
//  rf_wr_data   out  8    reg-file write data
//  rf_rd_data   in   8    reg-file read data, valid with rf_rd_valid
//  rf_rd_valid  in   1    read data valid pulse
//  alu_en       out  1    ALU start strobe (1 cycle)
//  alu_fun      out  4    ALU function, held from alu_en until alu_out_valid
//  alu_out      in   16   ALU result, valid with alu_out_valid
//  alu_out_valid in  1    ALU result valid pulse
//  clk_gate_en  out  1    ALU clock-gate enable
//  tx_p_data    out  8    byte to transmit
//  tx_d_valid   out  1    transmit request (level, see handshake)
//  tx_busy      in   1    UART_TX busy
// BEHAVIOUR
//  Reset: every output 0, FSM in IDLE. A reset mid-command aborts it; no strobe follows.
//  Commands (first byte):
//   0xAA addr data         -> rf write data@addr[3:0]; no TX reply
//   0xBB addr              -> rf read addr[3:0]; reply 1 byte
//   0xCC opA opB fun       -> write opA@0, opB@1, run ALU fun[3:0]; reply 2 bytes
//   0xDD fun               -> run ALU on current addr0/addr1; reply 2 bytes
//   any other first byte   -> ignored, stay IDLE
//  States: IDLE, WR_ADDR, WR_DATA, RD_ADDR, RD_WAIT, ALU_A, ALU_B, ALU_FUN, ALU_WAIT, TX_LO, TX_HI.
//  Byte accepted only on rx_d_valid=1 & rx_frame_err=0. A byte with rx_frame_err=1 aborts
//  the frame -> IDLE, no rf/ALU strobe, no reply.
//  Outputs are registered. Strobes fire on the cycle after the accepting rx_d_valid:
//   0xAA: rf_wr_en=1 with rf_addr/rf_wr_data for exactly 1 cycle, then IDLE.
//   0xBB: rf_rd_en=1 for 1 cycle; RD_WAIT until rf_rd_valid; latch rf_rd_data -> TX_LO.
//   0xCC: rf_wr_en@addr0 after opA byte, rf_wr_en@addr1 after opB byte; after fun byte
//         clk_gate_en=1, alu_en=1 next cycle for 1 cycle.
//   0xDD: clk_gate_en=1 and, on the cycle after, alu_en=1 for 1 cycle.
//   ALU_WAIT until alu_out_valid; latch 16-bit result; clk_gate_en drops next cycle.
//  TX handshake, per byte: wait tx_busy=0; drive tx_p_data, tx_d_valid=1 (data stable)
//  until tx_busy=1 is sampled, then tx_d_valid=0. The next byte waits for tx_busy=0 again.
//  ALU reply is LSB first (TX_LO=alu_out[7:0], TX_HI=alu_out[15:8]). Read reply uses TX_LO only.
//  New rx bytes arriving during RD_WAIT/ALU_WAIT/TX_* are dropped (no queueing).
//  Only one of rf_wr_en, rf_rd_en, alu_en is high in any cycle.
// TESTING
//  1 AA,05,3C -> one rf_wr_en pulse, rf_addr=5, rf_wr_data=0x3C; tx_d_valid stays 0.
//  2 BB,05, rf_rd_data=0x3C -> rf_rd_en=1, rf_addr=5; then tx_p_data=0x3C, one TX handshake.
//  3 CC,12,34,00 (add), alu_out=0x0046 -> writes 0x12@0, 0x34@1; alu_en pulse, fun=0;
//    TX bytes 0x46 then 0x00, each held until tx_busy rises.
//  4 DD,02 with tx_busy held 1 for 50 cycles -> tx_d_valid waits; sends only after tx_busy=0.
//  5 AA,07 followed by a byte with rx_frame_err=1 -> no rf_wr_en; next AA,07,FF writes 0xFF@7.
//  6 rst=1 during ALU_WAIT -> outputs 0 next cycle; alu_out_valid afterwards gives no TX.

Source files
------------

// File: rtl/uart_cmd_ctrl.sv
// Command sequencer between UART RX/TX, the register file and the ALU.
// Parses AA/BB/CC/DD frames, issues one-cycle strobes and returns result bytes over TX.
module uart_cmd_ctrl #(
    parameter int DATA_WIDTH    = 8,
    parameter int ADDR_WIDTH    = 4,
    parameter int ALU_FUN_WIDTH = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [DATA_WIDTH-1:0]     rx_p_data,
    input  logic                      rx_d_valid,
    input  logic                      rx_frame_err,
    output logic                      rf_wr_en,
    output logic                      rf_rd_en,
    output logic [ADDR_WIDTH-1:0]     rf_addr,
    output logic [DATA_WIDTH-1:0]     rf_wr_data,
    input  logic [DATA_WIDTH-1:0]     rf_rd_data,
    input  logic                      rf_rd_valid,
    output logic                      alu_en,
    output logic [ALU_FUN_WIDTH-1:0]  alu_fun,
    input  logic [2*DATA_WIDTH-1:0]   alu_out,
    input  logic                      alu_out_valid,
    output logic                      clk_gate_en,
    output logic [DATA_WIDTH-1:0]     tx_p_data,
    output logic                      tx_d_valid,
    input  logic                      tx_busy
);

    typedef enum logic [3:0] {
        IDLE, WR_ADDR, WR_DATA, RD_ADDR, RD_WAIT,
        ALU_A, ALU_B, ALU_FUN, ALU_WAIT, TX_LO, TX_HI
    } state_t;

    state_t                     r_state, w_state_next;
    logic                       r_rf_wr_en, w_rf_wr_en_next;
    logic                       r_rf_rd_en, w_rf_rd_en_next;
    logic [ADDR_WIDTH-1:0]      r_rf_addr, w_rf_addr_next;
    logic [DATA_WIDTH-1:0]      r_rf_wr_data, w_rf_wr_data_next;
    logic                       r_alu_en, w_alu_en_next;
    logic [ALU_FUN_WIDTH-1:0]   r_alu_fun, w_alu_fun_next;
    logic                       r_clk_gate_en, w_clk_gate_en_next;
    logic [DATA_WIDTH-1:0]      r_tx_p_data, w_tx_p_data_next;
    logic                       r_tx_d_valid, w_tx_d_valid_next;
    logic [2*DATA_WIDTH-1:0]    r_result, w_result_next;
    logic                       r_two_bytes, w_two_bytes_next;
    logic                       r_alu_go, w_alu_go_next;
    logic                       w_accept, w_abort;

    assign w_accept = rx_d_valid & ~rx_frame_err;
    assign w_abort  = rx_d_valid & rx_frame_err;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= IDLE;
            r_rf_wr_en    <= 1'b0;
            r_rf_rd_en    <= 1'b0;
            r_rf_addr     <= '0;
            r_rf_wr_data  <= '0;
            r_alu_en      <= 1'b0;
            r_alu_fun     <= '0;
            r_clk_gate_en <= 1'b0;
            r_tx_p_data   <= '0;
            r_tx_d_valid  <= 1'b0;
            r_result      <= '0;
            r_two_bytes   <= 1'b0;
            r_alu_go      <= 1'b0;
        end else begin
            r_state       <= w_state_next;
            r_rf_wr_en    <= w_rf_wr_en_next;
            r_rf_rd_en    <= w_rf_rd_en_next;
            r_rf_addr     <= w_rf_addr_next;
            r_rf_wr_data  <= w_rf_wr_data_next;
            r_alu_en      <= w_alu_en_next;
            r_alu_fun     <= w_alu_fun_next;
            r_clk_gate_en <= w_clk_gate_en_next;
            r_tx_p_data   <= w_tx_p_data_next;
            r_tx_d_valid  <= w_tx_d_valid_next;
            r_result      <= w_result_next;
            r_two_bytes   <= w_two_bytes_next;
            r_alu_go      <= w_alu_go_next;
        end
    end

    always_comb begin
        w_state_next       = r_state;
        w_rf_wr_en_next    = 1'b0;
        w_rf_rd_en_next    = 1'b0;
        w_alu_en_next      = 1'b0;
        w_alu_go_next      = 1'b0;
        w_rf_addr_next     = r_rf_addr;
        w_rf_wr_data_next  = r_rf_wr_data;
        w_alu_fun_next     = r_alu_fun;
        w_clk_gate_en_next = r_clk_gate_en;
        w_tx_p_data_next   = r_tx_p_data;
        w_tx_d_valid_next  = r_tx_d_valid;
        w_result_next      = r_result;
        w_two_bytes_next   = r_two_bytes;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    case (rx_p_data)
                        8'hAA:   w_state_next = WR_ADDR;
                        8'hBB:   w_state_next = RD_ADDR;
                        8'hCC:   w_state_next = ALU_A;
                        8'hDD:   w_state_next = ALU_FUN;
                        default: w_state_next = IDLE;
                    endcase
                end
            end
            WR_ADDR: begin
                if (w_abort) begin
                    w_state_next = IDLE;
                end else if (w_accept) begin
                    w_rf_addr_next = rx_p_data[ADDR_WIDTH-1:0];
                    w_state_next   = WR_DATA;
                end
            end
            WR_DATA: begin
                if (w_abort) begin
                    w_state_next = IDLE;
                end else if (w_accept) begin
                    w_rf_wr_en_next   = 1'b1;
                    w_rf_wr_data_next = rx_p_data;
                    w_state_next      = IDLE;
                end
            end
            RD_ADDR: begin
                if (w_abort) begin
                    w_state_next = IDLE;
                end else if (w_accept) begin
                    w_rf_rd_en_next = 1'b1;
                    w_rf_addr_next  = rx_p_data[ADDR_WIDTH-1:0];
                    w_state_next    = RD_WAIT;
                end
            end
            RD_WAIT: begin
                if (rf_rd_valid) begin
                    w_result_next    = {{DATA_WIDTH{1'b0}}, rf_rd_data};
                    w_two_bytes_next = 1'b0;
                    w_state_next     = TX_LO;
                end
            end
            ALU_A, ALU_B: begin
                if (w_abort) begin
                    w_state_next = IDLE;
                end else if (w_accept) begin
                    w_rf_wr_en_next   = 1'b1;
                    w_rf_wr_data_next = rx_p_data;
                    w_rf_addr_next    = (r_state == ALU_A) ? ADDR_WIDTH'(0) : ADDR_WIDTH'(1);
                    w_state_next      = (r_state == ALU_A) ? ALU_B : ALU_FUN;
                end
            end
            ALU_FUN: begin
                if (w_abort) begin
                    w_state_next = IDLE;
                end else if (w_accept) begin
                    // Gate opens first; alu_en follows one cycle later via r_alu_go.
                    w_clk_gate_en_next = 1'b1;
                    w_alu_fun_next     = rx_p_data[ALU_FUN_WIDTH-1:0];
                    w_alu_go_next      = 1'b1;
                    w_state_next       = ALU_WAIT;
                end
            end
            ALU_WAIT: begin
                if (r_alu_go) begin
                    w_alu_en_next = 1'b1;
                end else if (alu_out_valid) begin
                    w_result_next      = alu_out;
                    w_clk_gate_en_next = 1'b0;
                    w_two_bytes_next   = 1'b1;
                    w_state_next       = TX_LO;
                end
            end
            TX_LO, TX_HI: begin
                // Request held until busy is seen; the next byte re-waits for busy low.
                if (r_tx_d_valid) begin
                    if (tx_busy) begin
                        w_tx_d_valid_next = 1'b0;
                        w_state_next = (r_state == TX_LO && r_two_bytes) ? TX_HI : IDLE;
                    end
                end else if (!tx_busy) begin
                    w_tx_d_valid_next = 1'b1;
                    w_tx_p_data_next  = (r_state == TX_LO) ? r_result[DATA_WIDTH-1:0]
                                                           : r_result[2*DATA_WIDTH-1:DATA_WIDTH];
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    assign rf_wr_en    = r_rf_wr_en;
    assign rf_rd_en    = r_rf_rd_en;
    assign rf_addr     = r_rf_addr;
    assign rf_wr_data  = r_rf_wr_data;
    assign alu_en      = r_alu_en;
    assign alu_fun     = r_alu_fun;
    assign clk_gate_en = r_clk_gate_en;
    assign tx_p_data   = r_tx_p_data;
    assign tx_d_valid  = r_tx_d_valid;

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// Scoreboard bench for uart_cmd_ctrl: directed frames push expected events,
// a negedge monitor pops and compares every strobe and TX byte the DUT produces.
module tb_uart_cmd_ctrl;

    localparam logic [3:0] K_WR = 4'h1, K_RD = 4'h2, K_ALU = 4'h3, K_TX = 4'h4;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  rx_p_data;
    logic        rx_d_valid;
    logic        rx_frame_err;
    logic        rf_wr_en, rf_rd_en, alu_en, clk_gate_en, tx_d_valid;
    logic [3:0]  rf_addr, alu_fun;
    logic [7:0]  rf_wr_data, tx_p_data;
    logic [7:0]  rf_rd_data;
    logic        rf_rd_valid;
    logic [15:0] alu_out;
    logic        alu_out_valid;
    logic        tx_busy;

    int          checks = 0;
    int          errors = 0;
    logic [15:0] exp_q[$];

    logic [7:0]  mem [16];
    int          busy_cnt = 0;
    bit          busy_force = 0;
    int          alu_cnt = 0;
    int          alu_lat = 4;
    logic [15:0] alu_result = 16'h0;
    logic        prev_valid = 1'b0;
    logic [7:0]  prev_data = 8'h0;

    always #5 clk = ~clk;

    assign tx_busy = (busy_cnt > 0) || busy_force;

    uart_cmd_ctrl dut (
        .clk(clk), .rst(rst),
        .rx_p_data(rx_p_data), .rx_d_valid(rx_d_valid), .rx_frame_err(rx_frame_err),
        .rf_wr_en(rf_wr_en), .rf_rd_en(rf_rd_en), .rf_addr(rf_addr), .rf_wr_data(rf_wr_data),
        .rf_rd_data(rf_rd_data), .rf_rd_valid(rf_rd_valid),
        .alu_en(alu_en), .alu_fun(alu_fun), .alu_out(alu_out), .alu_out_valid(alu_out_valid),
        .clk_gate_en(clk_gate_en),
        .tx_p_data(tx_p_data), .tx_d_valid(tx_d_valid), .tx_busy(tx_busy)
    );

    function automatic logic [15:0] ev(input logic [3:0] k, input logic [3:0] a, input logic [7:0] d);
        return {k, a, d};
    endfunction

    task automatic check_ev(input logic [15:0] got, input string name);
        logic [15:0] e;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL %s: got event %h, expected none", name, got);
        end else begin
            e = exp_q.pop_front();
            if (got !== e) begin
                errors++;
                $display("FAIL %s: got %h, expected %h", name, got, e);
            end else begin
                $display("txn %s: %h ok", name, got);
            end
        end
    endtask

    task automatic check_val(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, got, want);
        end else begin
            $display("txn %s: %h ok", name, got);
        end
    endtask

    // Environment models: register file, fixed-latency ALU, UART TX busy window.
    always @(negedge clk) begin
        rf_rd_valid   = 1'b0;
        alu_out_valid = 1'b0;
        if (rf_wr_en) mem[rf_addr] = rf_wr_data;
        if (rf_rd_en) begin
            rf_rd_valid = 1'b1;
            rf_rd_data  = mem[rf_addr];
        end
        if (alu_cnt > 0) begin
            alu_cnt--;
            if (alu_cnt == 0) begin
                alu_out_valid = 1'b1;
                alu_out       = alu_result;
            end
        end
        if (alu_en) alu_cnt = alu_lat;
        if (busy_cnt > 0) busy_cnt--;
        else if (tx_d_valid && !busy_force) busy_cnt = 6;
    end

    // Monitor: every DUT-produced event is matched against the scoreboard.
    always @(negedge clk) begin
        if (!rst) begin
            if (rf_wr_en) check_ev(ev(K_WR, rf_addr, rf_wr_data), "rf_wr");
            if (rf_rd_en) check_ev(ev(K_RD, rf_addr, 8'h00), "rf_rd");
            if (alu_en)   check_ev(ev(K_ALU, 4'h0, {4'h0, alu_fun}), "alu_en");
            if (tx_d_valid && !prev_valid) check_ev(ev(K_TX, 4'h0, tx_p_data), "tx_byte");
            if (tx_d_valid && prev_valid) check_val("tx_stable", {24'h0, tx_p_data}, {24'h0, prev_data});
            if (rf_wr_en || rf_rd_en || alu_en)
                check_val("one_strobe", $countones({rf_wr_en, rf_rd_en, alu_en}), 32'd1);
        end
        prev_valid = tx_d_valid;
        prev_data  = tx_p_data;
    end

    task automatic send(input logic [7:0] b, input logic err);
        @(negedge clk);
        rx_p_data    = b;
        rx_d_valid   = 1'b1;
        rx_frame_err = err;
        @(negedge clk);
        rx_d_valid   = 1'b0;
        rx_frame_err = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || tx_d_valid || tx_busy) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= 2000) begin
            errors++;
            $display("FAIL %s: timeout, %0d events still pending, expected 0", name, exp_q.size());
        end
        repeat (5) @(negedge clk);
    endtask

    task automatic check_reset(input string name);
        check_val(name, {rf_wr_en, rf_rd_en, alu_en, clk_gate_en, tx_d_valid,
                         rf_addr, rf_wr_data, alu_fun, tx_p_data}, 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bit seen;
        for (int i = 0; i < 16; i++) mem[i] = 8'h00;
        rst = 1'b1; rx_p_data = 8'h0; rx_d_valid = 1'b0; rx_frame_err = 1'b0;
        rf_rd_data = 8'h0; alu_out = 16'h0;
        repeat (3) @(negedge clk);
        check_reset("reset_state");
        rst = 1'b0;

        // 1: register write
        exp_q.push_back(ev(K_WR, 4'h5, 8'h3C));
        send(8'hAA, 0); send(8'h05, 0); send(8'h3C, 0);
        wait_drain("t1_write");

        // 2: register read, single-byte reply
        exp_q.push_back(ev(K_RD, 4'h5, 8'h00));
        exp_q.push_back(ev(K_TX, 4'h0, 8'h3C));
        send(8'hBB, 0); send(8'h05, 0);
        wait_drain("t2_read");

        // 3: load operands and run ALU add
        alu_result = 16'h0046;
        exp_q.push_back(ev(K_WR, 4'h0, 8'h12));
        exp_q.push_back(ev(K_WR, 4'h1, 8'h34));
        exp_q.push_back(ev(K_ALU, 4'h0, 8'h00));
        exp_q.push_back(ev(K_TX, 4'h0, 8'h46));
        exp_q.push_back(ev(K_TX, 4'h0, 8'h00));
        send(8'hCC, 0); send(8'h12, 0); send(8'h34, 0); send(8'h00, 0);
        wait_drain("t3_alu_cc");

        // 4: ALU reply held back by a long busy window
        alu_result = 16'hBEEF;
        busy_force = 1;
        exp_q.push_back(ev(K_ALU, 4'h0, 8'h02));
        exp_q.push_back(ev(K_TX, 4'h0, 8'hEF));
        exp_q.push_back(ev(K_TX, 4'h0, 8'hBE));
        send(8'hDD, 0); send(8'h02, 0);
        seen = 0;
        repeat (50) begin
            @(negedge clk);
            if (tx_d_valid) seen = 1;
        end
        check_val("t4_tx_held_while_busy", {31'h0, seen}, 32'h0);
        check_val("t4_gate_dropped", {31'h0, clk_gate_en}, 32'h0);
        busy_force = 0;
        wait_drain("t4_alu_dd");

        // 5: ignored opcode, aborted frame, then a clean write
        exp_q.push_back(ev(K_WR, 4'h7, 8'hFF));
        send(8'h55, 0);
        send(8'hAA, 0); send(8'h07, 0); send(8'h99, 1);
        send(8'hAA, 0); send(8'h07, 0); send(8'hFF, 0);
        wait_drain("t5_frame_err");

        // 6: reset while waiting on the ALU
        alu_lat = 20;
        alu_result = 16'h1234;
        exp_q.push_back(ev(K_ALU, 4'h0, 8'h03));
        send(8'hDD, 0); send(8'h03, 0);
        repeat (3) @(negedge clk);
        check_val("t6_gate_on", {31'h0, clk_gate_en}, 32'h1);
        rst = 1'b1;
        @(negedge clk);
        check_reset("t6_reset_outputs");
        rst = 1'b0;
        seen = 0;
        repeat (30) begin
            @(negedge clk);
            if (tx_d_valid) seen = 1;
        end
        check_val("t6_no_tx_after_reset", {31'h0, seen}, 32'h0);
        check_val("final_queue_empty", exp_q.size(), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
